// File: rtl/tdm_demux_if.sv
// Stream and frame bundle for tdm_demux: slot-sequenced beats in, published frame and status out.
// TDM_DEMUX_ERRCNT_EN adds clr_err / err_cnt to the bundle.
interface tdm_demux_if #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
);
    localparam int unsigned SW = $clog2(N);

    logic [W-1:0]   d;
    logic           d_valid;
    logic           sync;
    logic [N*W-1:0] q;
    logic           frame_valid;
    logic [SW-1:0]  slot;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic           clr_err;
    logic [7:0]     err_cnt;

    modport master (
        output d, d_valid, sync, clr_err,
        input  q, frame_valid, slot, locked, sync_err, err_cnt
    );
    modport slave (
        input  d, d_valid, sync, clr_err,
        output q, frame_valid, slot, locked, sync_err, err_cnt
    );
`else
    modport master (
        output d, d_valid, sync,
        input  q, frame_valid, slot, locked, sync_err
    );
    modport slave (
        input  d, d_valid, sync,
        output q, frame_valid, slot, locked, sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: sorts slot-sequenced beats into shadow registers and publishes whole frames.
// Optional sync-error counter enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [SW-1:0]  slot_r;
    logic [SW-1:0]  slot_next;
    logic [W-1:0]   shadow [N];
    logic [W-1:0]   shadow_next [N];
    logic [N*W-1:0] q_r;
    logic [N*W-1:0] q_next;
    logic           fv_r;
    logic           fv_next;
    logic           serr_r;
    logic           serr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            slot_r <= '0;
            q_r    <= '0;
            fv_r   <= 1'b0;
            serr_r <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state  <= state_next;
            slot_r <= slot_next;
            q_r    <= q_next;
            fv_r   <= fv_next;
            serr_r <= serr_next;
            for (int unsigned k = 0; k < N; k++) begin
                shadow[k] <= shadow_next[k];
            end
        end
    end

    always_comb begin
        state_next  = state;
        slot_next   = slot_r;
        shadow_next = shadow;
        q_next      = q_r;
        fv_next     = 1'b0;
        serr_next   = 1'b0;
        if (bus.d_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sync) begin
                        shadow_next[0] = bus.d;
                        slot_next      = SW'(1);
                        state_next     = RUN;
                    end
                end
                RUN: begin
                    // A sync landing mid-frame restarts the frame; the partial one is never published.
                    if (bus.sync && (slot_r != '0)) begin
                        serr_next      = 1'b1;
                        shadow_next[0] = bus.d;
                        slot_next      = SW'(1);
                    end else begin
                        shadow_next[slot_r] = bus.d;
                        if (slot_r == LAST_SLOT) begin
                            slot_next = '0;
                            fv_next   = 1'b1;
                            for (int unsigned k = 0; k < N; k++) begin
                                q_next[k*W +: W] = shadow_next[k];
                            end
                        end else begin
                            slot_next = slot_r + SW'(1);
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (bus.clr_err) begin
            err_cnt_r <= '0;
        end else if (serr_next && (err_cnt_r != '1)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`endif

    assign bus.q           = q_r;
    assign bus.frame_valid = fv_r;
    assign bus.slot        = slot_r;
    assign bus.locked      = (state == RUN);
    assign bus.sync_err    = serr_r;
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: queue-based frame model compared every cycle, plus directed literals.
module tb_tdm_demux;
    localparam int unsigned W = 4;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_if #(.W(W), .N(N)) bus ();

    tdm_demux #(.W(W), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int fv_pulses  = 0;
    int serr_pulses = 0;

    // Model: the beats gathered since the last frame boundary; slot is simply how many there are.
    bit             m_locked = 1'b0;
    logic [W-1:0]   m_frame[$];
    logic [N*W-1:0] m_q = '0;
    bit             m_fv = 1'b0;
    bit             m_serr = 1'b0;
    int             m_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_fv   = 1'b0;
        m_serr = 1'b0;
        if (rst) begin
            m_locked = 1'b0;
            m_frame.delete();
            m_q   = '0;
            m_err = 0;
        end else begin
            if (bus.d_valid) begin
                if (!m_locked) begin
                    if (bus.sync) begin
                        m_locked = 1'b1;
                        m_frame.delete();
                        m_frame.push_back(bus.d);
                    end
                end else if (bus.sync && m_frame.size() != 0) begin
                    m_serr = 1'b1;
                    m_frame.delete();
                    m_frame.push_back(bus.d);
                end else begin
                    m_frame.push_back(bus.d);
                    if (m_frame.size() == N) begin
                        for (int k = 0; k < N; k++) m_q[k*W +: W] = m_frame[k];
                        m_fv = 1'b1;
                        m_frame.delete();
                    end
                end
            end
`ifdef TDM_DEMUX_ERRCNT_EN
            if (bus.clr_err) m_err = 0;
            else if (m_serr && m_err < 255) m_err++;
`endif
        end
    endtask

    task automatic compare_all();
        check("q", 64'(bus.q), 64'(m_q));
        check("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
        check("slot", 64'(bus.slot), 64'(m_frame.size()));
        check("locked", 64'(bus.locked), 64'(m_locked));
        check("sync_err", 64'(bus.sync_err), 64'(m_serr));
`ifdef TDM_DEMUX_ERRCNT_EN
        check("err_cnt", 64'(bus.err_cnt), 64'(m_err));
`endif
        if (bus.frame_valid === 1'b1) fv_pulses++;
        if (bus.sync_err === 1'b1) serr_pulses++;
    endtask

    // One clock: model updates on the edge, outputs compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic beat(input logic [W-1:0] v, input logic s);
        bus.d       = v;
        bus.sync    = s;
        bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        bus.sync    = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.d_valid = 1'b0;
        bus.sync    = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int p;
        bus.d       = '0;
        bus.d_valid = 1'b0;
        bus.sync    = 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
        bus.clr_err = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_q", 64'(bus.q), 64'h0);
        check("rst_locked", 64'(bus.locked), 64'h0);
        check("rst_slot", 64'(bus.slot), 64'h0);

        // Beats without sync while hunting are dropped.
        p = fv_pulses;
        beat(4'h1, 1'b0); beat(4'h2, 1'b0); beat(4'h3, 1'b0);
        idle(2);
        check("hunt_locked", 64'(bus.locked), 64'h0);
        check("hunt_slot", 64'(bus.slot), 64'h0);
        check("hunt_q", 64'(bus.q), 64'h0);
        check("hunt_fv_count", 64'(fv_pulses - p), 64'h0);

        // Back-to-back frame.
        beat(4'h1, 1'b1); beat(4'h2, 1'b0); beat(4'h3, 1'b0); beat(4'h4, 1'b0);
        check("f1_fv", 64'(bus.frame_valid), 64'h1);
        check("f1_q", 64'(bus.q), 64'h4321);
        check("f1_slot", 64'(bus.slot), 64'h0);
        check("f1_locked", 64'(bus.locked), 64'h1);
        idle(1);
        check("f1_fv_drop", 64'(bus.frame_valid), 64'h0);

        // Same frame with gaps.
        p = fv_pulses;
        beat(4'h1, 1'b1); idle(2);
        check("gap_slot_hold", 64'(bus.slot), 64'h1);
        beat(4'h2, 1'b0); idle(2);
        beat(4'h3, 1'b0); idle(2);
        check("gap_slot3", 64'(bus.slot), 64'h3);
        beat(4'h4, 1'b0);
        check("gap_q", 64'(bus.q), 64'h4321);
        idle(3);
        check("gap_fv_count", 64'(fv_pulses - p), 64'h1);

        // Misaligned sync restarts the frame.
        beat(4'hA, 1'b0); beat(4'hB, 1'b0); beat(4'h5, 1'b1);
        check("mis_serr", 64'(bus.sync_err), 64'h1);
        check("mis_fv", 64'(bus.frame_valid), 64'h0);
        check("mis_q_hold", 64'(bus.q), 64'h4321);
        check("mis_slot", 64'(bus.slot), 64'h1);
        beat(4'h6, 1'b0); beat(4'h7, 1'b0); beat(4'h8, 1'b0);
        check("mis_q", 64'(bus.q), 64'h8765);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("mis_err_cnt", 64'(bus.err_cnt), 64'h1);
`endif

        // Reset mid-frame discards the partial frame and clears q.
        beat(4'h1, 1'b1); beat(4'h2, 1'b0); beat(4'h3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_q", 64'(bus.q), 64'h0);
        check("mrst_locked", 64'(bus.locked), 64'h0);
        p = serr_pulses;
        beat(4'h9, 1'b1); beat(4'hA, 1'b0); beat(4'hB, 1'b0);
        check("mrst_q_hold", 64'(bus.q), 64'h0);
        beat(4'hC, 1'b0);
        check("mrst_q_new", 64'(bus.q), 64'hCBA9);
        idle(1);
        check("mrst_serr_count", 64'(serr_pulses - p), 64'h0);

`ifdef TDM_DEMUX_ERRCNT_EN
        beat(4'h1, 1'b1);
        for (int i = 0; i < 300; i++) beat(4'(i), 1'b1);
        check("sat_err_cnt", 64'(bus.err_cnt), 64'd255);
        bus.clr_err = 1'b1;
        beat(4'h3, 1'b1);
        bus.clr_err = 1'b0;
        check("clr_serr", 64'(bus.sync_err), 64'h1);
        check("clr_err_cnt", 64'(bus.err_cnt), 64'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            bus.d       = 4'($urandom);
            bus.d_valid = ($urandom_range(0, 9) < 6);
            bus.sync    = ($urandom_range(0, 7) == 0);
`ifdef TDM_DEMUX_ERRCNT_EN
            bus.clr_err = ($urandom_range(0, 49) == 0);
`endif
            tick();
        end
        rst = 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
        bus.clr_err = 1'b0;
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a slot-sequenced 2:1/N:1 mux channel.
- Takes one W-bit stream in which consecutive valid beats belong to slots 0..N-1, marked by a sync strobe on slot 0.
- Routes each beat into a per-slot shadow register and publishes a complete frame atomically on N parallel outputs.
- Sits after the lab mux datapath to recover the individual channels.

Parameters:
- W, 4, data width per slot.
- N, 4, slots per frame (2..16); slot counter width is $clog2(N).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- d  in  W  multiplexed data beat.
- d_valid  in  1  beat qualifier; beat accepted when high on a rising edge.
- sync  in  1  marks the accompanying valid beat as slot 0; ignored when d_valid=0.
- q  out  N*W  published frame; slot k occupies q[k*W +: W].
- frame_valid  out  1  one-cycle pulse when q is updated.
- slot  out  $clog2(N)  slot index the next accepted beat will fill.
- locked  out  1  high in RUN state.
- sync_err  out  1  one-cycle pulse on sync misalignment.

Behaviour:
- Reset (Clock edge with Reset=1): q=0, shadow=0, frame_valid=0, slot=0, locked=0, sync_err=0, state=HUNT. Reset overrides any in-flight beat; a partial frame is discarded.
- States: HUNT, RUN.
- HUNT:
  - Valid beats without sync are dropped.
  - Valid beat with sync: write shadow[0]=d, slot<=1, go to RUN.
  - If N would make slot wrap immediately (not possible, since N>=2), no special case is needed.
- RUN, valid beat without sync: shadow[slot]=d.
  - If slot==N-1: slot<=0, copy the full shadow (including this beat) to q, pulse frame_valid next cycle.
  - Else: slot<=slot+1.
- RUN, valid beat with sync at slot==0: normal slot-0 write; no error.
- RUN, valid beat with sync at slot!=0:
  - Pulse sync_err.
  - Discard the partial frame; q is not updated and frame_valid stays 0.
  - Treat the beat as the new slot 0: shadow[0]=d, slot<=1, stay in RUN.
- Sync absent at a slot-0 beat in RUN: accepted as slot 0. The block free-runs on its count; there is no loss-of-lock state.
- d_valid=0: no state change, and slot holds its value; gaps of any length between beats are legal.
- Latency:
  - The last-slot beat is sampled on edge t.
  - q and frame_valid=1 are visible after edge t; frame_valid drops after edge t+1 unless another frame completes, which requires N>=2 beats, so no back-to-back pulses.
- q holds its last published frame until the next completed frame; there is no partial visibility.
- Shadow slots not yet rewritten after a resync retain stale data but are always overwritten before publication.
- locked=1 exactly when state=RUN.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: TDM_DEMUX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset to 0.
  - Increments on every sync_err pulse and saturates at 255.
  - Input clr_err (1 bit): synchronous clear. Clear takes priority over a simultaneous increment.
- Undefined: err_cnt and clr_err ports do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 3 valid beats with no sync -> locked=0, slot=0, q=0, frame_valid never asserted.
- N=4, W=4: sync+0x1, then 0x2, 0x3, 0x4 on consecutive cycles -> frame_valid one cycle after the 4th beat, q=0x4321, slot=0, locked=1.
- Same frame with d_valid=0 gaps of 2 cycles between beats -> identical q=0x4321, single frame_valid pulse, slot holds across gaps.
- After lock: 0xA, 0xB (slots 0,1), then sync+0x5, 0x6, 0x7, 0x8 -> sync_err pulse on the sync beat, no publish of the partial frame, then q=0x8765; with TDM_DEMUX_ERRCNT_EN defined, err_cnt=1.
- Reset asserted after slot 2 of a frame, then a full frame 0x9,0xA,0xB,0xC with sync on the first beat -> q=0 until the new frame publishes q=0xCBA9, no sync_err.
- TDM_DEMUX_ERRCNT_EN defined: force 300 misaligned syncs -> err_cnt=255; clr_err and a sync_err in the same cycle -> err_cnt=0.
